ks_adder_pipe: RTL and testbench
================================

# ks_adder_pipe

Parametrised, segment-pipelined Kogge-Stone adder/subtractor. It generalises the team's fixed 32-bit registered and two-stage pipelined adders to any width and any pipeline depth. It adds subtract mode, signed-overflow detection, a valid qualifier and a global stall. It sits in the datapath wherever a wide add must close timing at a target clock, with depth traded against frequency through one parameter.

## Interface
- BW, 32: operand/result width; BW >= 2.
- SEG, 2: pipeline segments and latency in cycles; 1 <= SEG <= BW, BW % SEG == 0; segment width W = BW/SEG.
- CLK  input  1  clock, rising edge.
- RESETn  input  1  asynchronous, active-low reset.
- en  input  1  global enable; 0 freezes every pipeline register (stall).
- in_valid  input  1  operand set on A/B/cin/sub is valid this cycle.
- sub  input  1  0: A + B + cin; 1: A - B (cin ignored).
- A  input  BW  operand A.
- B  input  BW  operand B.
- cin  input  1  carry in (add mode only).
- out_valid  output  1  sum/cout/ovf hold a valid result.
- sum  output  BW  result, registered.
- cout  output  1  carry out of bit BW-1 (subtract: 1 = no borrow).
- ovf  output  1  two's-complement signed overflow.

## Operation
- Effective operands: Be = sub ? ~B : B; c0 = sub ? 1 : cin.
- Segment k (k = 0..SEG-1) covers bits [k*W +: W]. It uses a W-bit Kogge-Stone prefix network: G/P generation, log2-depth black/grey cells, and grey cells folding in the segment carry-in.
- Stage k+1 register captures segment k's sum bits and its carry-out. That carry-out feeds segment k+1 in the following stage.
- Skew registers delay the upper A/Be segments so each segment meets its carry in the correct cycle. De-skew registers delay the lower sum segments so all BW bits leave together.
- in_valid travels through a SEG-deep valid shift chain alongside the data. Bubbles (in_valid=0) propagate as out_valid=0. Data registers may load regardless of valid.
- cout = carry out of segment SEG-1.
- ovf = carry into bit BW-1 XOR carry out of bit BW-1. This requires segment SEG-1 to expose its internal bit BW-2 carry.
- SEG=1 degenerates to a single-register adder: combinational KS, then output flops.
- Arithmetic is modulo 2^BW. No saturation.

## Timing
- Latency: an operand accepted at edge t (en=1) appears on outputs after edge t+SEG-1. This counts only cycles with en=1; SEG=1 means the result is visible right after the capturing edge.
- Throughput: one operation per enabled cycle. Back-to-back in_valid is fully supported.
- en=0: all skew, de-skew, valid and output registers hold. Outputs stay stable. Inputs during a stalled cycle are not captured.
- Reset (asynchronous assert, any cycle, including mid-stream): sum=0, cout=0, ovf=0, out_valid=0, and all internal pipeline and valid registers cleared. In-flight operations are discarded.
- First out_valid after reset release is exactly SEG enabled cycles after the first accepted in_valid.
- Simultaneous sub change between consecutive operations: each operation uses its own sub/cin, carried down the pipe with its data. There is no cross-talk.

## Test plan
- BW=32, SEG=2, add: A=0x0000FFFF, B=0x00000001, cin=0 -> after 2 cycles sum=0x00010000, cout=0, ovf=0, out_valid=1. This exercises the cross-segment carry.
- Add boundaries: A=0xFFFFFFFF, B=1, cin=0 -> sum=0x00000000, cout=1, ovf=0. A=0x7FFFFFFF, B=1 -> sum=0x80000000, cout=0, ovf=1.
- Subtract: A=5, B=7, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0. A=0x80000000, B=1, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Streaming with stall, SEG=4: issue 8 back-to-back random add/sub ops, hold en=0 for 3 cycles mid-stream, interleave one in_valid=0 bubble. Results must match a golden model in order, with out_valid low exactly at the bubble and outputs frozen during the stall.
- Reset mid-operation: SEG=4, 3 ops in flight, assert RESETn=0 asynchronously between edges -> outputs 0 immediately. After release with no new input, out_valid stays 0.
- Parameter sweep: (BW,SEG) in {(8,1),(16,4),(32,32),(64,8)}, 1000 random ops each -> exact match on sum/cout/ovf against the reference model, with latency equal to SEG.

Source files
------------

// File: rtl/ks_adder_pipe.sv
// Segment-pipelined Kogge-Stone adder/subtractor: BW bits split into SEG segments,
// one segment resolved per stage, carry handed to the next segment one cycle later.
module ks_adder_pipe #(
  parameter int unsigned BW  = 32,
  parameter int unsigned SEG = 2
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          en,
  input  logic          in_valid,
  input  logic          sub,
  input  logic [BW-1:0] A,
  input  logic [BW-1:0] B,
  input  logic          cin,
  output logic          out_valid,
  output logic [BW-1:0] sum,
  output logic          cout,
  output logic          ovf
);

  localparam int unsigned W = BW / SEG;

  logic [BW-1:0] b_eff;
  logic          c0;

  // Subtract is A + ~B + 1; the effective operand travels down the pipe with its data.
  assign b_eff = sub ? ~B : B;
  assign c0    = sub | cin;

  // W-bit Kogge-Stone carry vector: returns {c[W], ..., c[1], c[0]=ci}.
  function automatic logic [W:0] ks_carry(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic ci);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] gn;
    logic [W-1:0] pn;
    logic [W:0]   c;
    g = a & b;
    p = a ^ b;
    for (int d = 1; d < int'(W); d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < int'(W); i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    c[0] = ci;
    // Grey cells fold the segment carry-in into every group prefix.
    for (int i = 0; i < int'(W); i++) begin
      c[i+1] = g[i] | (p[i] & ci);
    end
    return c;
  endfunction

  genvar k;

  // Skew registers: stage k holds the operand bits above segment k for later segments.
  for (k = 0; k < int'(SEG) - 1; k++) begin : g_skew
    localparam int unsigned UW = BW - (k + 1) * W;
    logic [UW-1:0] a_d;
    logic [UW-1:0] b_d;
    logic [UW-1:0] a_q;
    logic [UW-1:0] b_q;

    if (k == 0) begin : g_src
      assign a_d = A[BW-1:W];
      assign b_d = b_eff[BW-1:W];
    end else begin : g_src
      assign a_d = g_skew[k-1].a_q[UW+W-1:W];
      assign b_d = g_skew[k-1].b_q[UW+W-1:W];
    end

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        a_q <= '0;
        b_q <= '0;
      end else if (en) begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end
  end

  // Segment stages: each resolves W bits and appends them to the de-skewed lower sum.
  for (k = 0; k < int'(SEG); k++) begin : g_stage
    logic [W-1:0]         sa;
    logic [W-1:0]         sb;
    logic [W-1:0]         ss;
    logic                 sci;
    logic                 vin;
    logic [W:0]           cv;
    logic [(k+1)*W-1:0]   s_d;
    logic [(k+1)*W-1:0]   s_q;
    logic                 c_q;
    logic                 v_q;

    if (k == 0) begin : g_src
      assign sa  = A[W-1:0];
      assign sb  = b_eff[W-1:0];
      assign sci = c0;
      assign vin = in_valid;
      assign s_d = ss;
    end else begin : g_src
      assign sa  = g_skew[k-1].a_q[W-1:0];
      assign sb  = g_skew[k-1].b_q[W-1:0];
      assign sci = g_stage[k-1].c_q;
      assign vin = g_stage[k-1].v_q;
      assign s_d = {ss, g_stage[k-1].s_q};
    end

    assign cv = ks_carry(sa, sb, sci);
    assign ss = sa ^ sb ^ cv[W-1:0];

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (en) begin
        s_q <= s_d;
        c_q <= cv[W];
        v_q <= vin;
      end
    end

    // Only the top segment sees bit BW-1, so only it can flag signed overflow.
    if (k == int'(SEG) - 1) begin : g_last
      logic ovf_q;
      always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= cv[W] ^ cv[W-1];
        end
      end
    end
  end

  assign sum       = g_stage[SEG-1].s_q;
  assign cout      = g_stage[SEG-1].c_q;
  assign out_valid = g_stage[SEG-1].v_q;
  assign ovf       = g_stage[SEG-1].g_last.ovf_q;

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Directed bench for ks_adder_pipe: several width/depth instances share one stimulus bus,
// expected values come from hand-computed constants and a plain integer-add model.
module tb_ks_adder_pipe;

  logic        CLK;
  logic        RESETn;
  logic        en;
  logic        in_valid;
  logic        sub;
  logic        cin;
  logic [63:0] A;
  logic [63:0] B;

  logic        ov2, co2, of2;
  logic [31:0] s2;
  logic        ov4, co4, of4;
  logic [31:0] s4;
  logic        ov81, co81, of81;
  logic [7:0]  s81;
  logic        ov164, co164, of164;
  logic [15:0] s164;
  logic        ov3232, co3232, of3232;
  logic [31:0] s3232;
  logic        ov648, co648, of648;
  logic [63:0] s648;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed {
    logic        v;
    logic [65:0] r;
  } ent_t;

  ks_adder_pipe #(.BW(32), .SEG(2)) u_d2 (
    .CLK(CLK), .RESETn(RESETn), .en(en), .in_valid(in_valid), .sub(sub),
    .A(A[31:0]), .B(B[31:0]), .cin(cin),
    .out_valid(ov2), .sum(s2), .cout(co2), .ovf(of2));

  ks_adder_pipe #(.BW(32), .SEG(4)) u_d4 (
    .CLK(CLK), .RESETn(RESETn), .en(en), .in_valid(in_valid), .sub(sub),
    .A(A[31:0]), .B(B[31:0]), .cin(cin),
    .out_valid(ov4), .sum(s4), .cout(co4), .ovf(of4));

  ks_adder_pipe #(.BW(8), .SEG(1)) u_d81 (
    .CLK(CLK), .RESETn(RESETn), .en(en), .in_valid(in_valid), .sub(sub),
    .A(A[7:0]), .B(B[7:0]), .cin(cin),
    .out_valid(ov81), .sum(s81), .cout(co81), .ovf(of81));

  ks_adder_pipe #(.BW(16), .SEG(4)) u_d164 (
    .CLK(CLK), .RESETn(RESETn), .en(en), .in_valid(in_valid), .sub(sub),
    .A(A[15:0]), .B(B[15:0]), .cin(cin),
    .out_valid(ov164), .sum(s164), .cout(co164), .ovf(of164));

  ks_adder_pipe #(.BW(32), .SEG(32)) u_d3232 (
    .CLK(CLK), .RESETn(RESETn), .en(en), .in_valid(in_valid), .sub(sub),
    .A(A[31:0]), .B(B[31:0]), .cin(cin),
    .out_valid(ov3232), .sum(s3232), .cout(co3232), .ovf(of3232));

  ks_adder_pipe #(.BW(64), .SEG(8)) u_d648 (
    .CLK(CLK), .RESETn(RESETn), .en(en), .in_valid(in_valid), .sub(sub),
    .A(A), .B(B), .cin(cin),
    .out_valid(ov648), .sum(s648), .cout(co648), .ovf(of648));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference: returns {ovf, cout, sum[63:0]} for a bw-bit add/subtract.
  function automatic logic [65:0] ref_add(input int unsigned bw, input logic [63:0] a,
                                          input logic [63:0] b, input logic s, input logic c);
    logic [64:0] m;
    logic [64:0] full;
    logic [63:0] be;
    logic [63:0] sm;
    logic        co;
    logic        ov;
    m    = (65'd1 << bw) - 65'd1;
    be   = s ? ~b : b;
    full = ({1'b0, a} & m) + ({1'b0, be} & m) + 65'(s ? 1'b1 : c);
    sm   = full[63:0] & m[63:0];
    co   = full[bw];
    ov   = (a[bw-1] == be[bw-1]) && (sm[bw-1] != a[bw-1]);
    return {ov, co, sm};
  endfunction

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated operation: latency on SEG=1/SEG=2, hand values on 32/2, model on the rest.
  task automatic op(input string tag, input logic [63:0] a, input logic [63:0] b,
                    input logic s, input logic c,
                    input logic [31:0] xs, input logic xc, input logic xo);
    @(negedge CLK);
    en = 1'b1; in_valid = 1'b1; A = a; B = b; sub = s; cin = c;
    @(posedge CLK);
    #1;
    chk({tag, "/seg1_valid"}, 66'(ov81), 66'(1'b1));
    chk({tag, "/seg2_early_valid"}, 66'(ov2), 66'(1'b0));
    @(negedge CLK);
    in_valid = 1'b0;
    @(posedge CLK);
    #1;
    chk({tag, "/valid"}, 66'(ov2), 66'(1'b1));
    chk({tag, "/sum"}, 66'(s2), 66'(xs));
    chk({tag, "/cout"}, 66'(co2), 66'(xc));
    chk({tag, "/ovf"}, 66'(of2), 66'(xo));
    repeat (34) @(posedge CLK);
    #1;
    chk({tag, "/w8s1"}, {of81, co81, 56'd0, s81}, ref_add(8, a, b, s, c));
    chk({tag, "/w16s4"}, {of164, co164, 48'd0, s164}, ref_add(16, a, b, s, c));
    chk({tag, "/w32s4"}, {of4, co4, 32'd0, s4}, ref_add(32, a, b, s, c));
    chk({tag, "/w32s32"}, {of3232, co3232, 32'd0, s3232}, ref_add(32, a, b, s, c));
    chk({tag, "/w64s8"}, {of648, co648, s648}, ref_add(64, a, b, s, c));
  endtask

  initial begin
    ent_t        pipe4 [4];
    logic [65:0] r;
    logic [63:0] ra, rb;
    logic        rs, rc, e, v;

    RESETn = 1'b0; en = 1'b0; in_valid = 1'b0; sub = 1'b0; cin = 1'b0;
    A = '0; B = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset/w32s2", {of2, co2, ov2, 31'd0, s2}, 66'd0);
    chk("reset/w32s4", {of4, co4, ov4, 31'd0, s4}, 66'd0);
    chk("reset/w64s8", {of648, co648, s648}, 66'd0);
    chk("reset/valids", 66'({ov81, ov164, ov3232, ov648}), 66'd0);
    @(negedge CLK);
    RESETn = 1'b1;

    op("add_cross_seg", 64'h0000FFFF, 64'h1, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0);
    op("add_wrap",      64'hFFFFFFFF, 64'h1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    op("add_ovf",       64'h7FFFFFFF, 64'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    op("sub_neg",       64'h5, 64'h7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    op("sub_ovf",       64'h80000000, 64'h1, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
    op("add_cin",       64'h12345678, 64'h11111111, 1'b0, 1'b1, 32'h2345678A, 1'b0, 1'b0);
    op("sub_equal",     64'hDEADBEEF, 64'hDEADBEEF, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);

    // Stream on 32/4: 8 accepted ops, a bubble at step 3, a 3-cycle stall at steps 5..7.
    for (int i = 0; i < 4; i++) pipe4[i] = '0;
    for (int i = 0; i < 20; i++) begin
      e  = !(i >= 5 && i <= 7);
      v  = (i != 3) && (i < 12);
      ra = {32'd0, $urandom};
      rb = {32'd0, $urandom};
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      @(negedge CLK);
      en = e; in_valid = v; A = ra; B = rb; sub = rs; cin = rc;
      @(posedge CLK);
      #1;
      if (e) begin
        for (int j = 3; j > 0; j--) pipe4[j] = pipe4[j-1];
        pipe4[0] = '{v: v, r: ref_add(32, ra, rb, rs, rc)};
      end
      chk($sformatf("stream%0d/valid", i), 66'(ov4), 66'(pipe4[3].v));
      if (pipe4[3].v) begin
        chk($sformatf("stream%0d/data", i), {of4, co4, 32'd0, s4}, pipe4[3].r);
      end
    end

    for (int i = 0; i < 30; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      r  = ref_add(32, ra, rb, rs, rc);
      op($sformatf("rand%0d", i), ra, rb, rs, rc, r[31:0], r[64], r[65]);
    end

    // Reset with the first result on the 32/4 outputs and three more ops in flight.
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      en = 1'b1; in_valid = 1'b1; sub = 1'b0; cin = 1'b0;
      A = 64'h11111111; B = 64'h22222222 + 64'(i);
    end
    @(posedge CLK);
    #1;
    chk("prereset/valid", 66'(ov4), 66'(1'b1));
    chk("prereset/sum", 66'(s4), 66'(32'h33333333));
    #1;
    RESETn = 1'b0;
    #1;
    chk("midreset/w32s4", {of4, co4, ov4, 31'd0, s4}, 66'd0);
    chk("midreset/w32s2", {of2, co2, ov2, 31'd0, s2}, 66'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("postreset%0d/valid", i), 66'({ov4, ov2, ov164}), 66'd0);
    end

    op("recover", 64'h0000FFFF, 64'h1, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
